// File: rtl/calc_pkg.sv
// calc_pkg: shared types and defaults for the calculator arithmetic stage.
package calc_pkg;

  // Default operand width; the result is twice this wide.
  localparam int CALC_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/calc_alu_if.sv
// calc_alu_if: request/result bundle between the operand capture stage,
// the arithmetic stage and the display stage.
interface calc_alu_if #(
  parameter int W = calc_pkg::CALC_W
);
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           neg;
  logic           err;

  // Requester side: issues operands and start, observes the result.
  modport master (
    output start, op, a, b,
    input  busy, done, result, neg, err
  );

  // Arithmetic stage side.
  modport slave (
    input  start, op, a, b,
    output busy, done, result, neg, err
  );
endinterface

// File: rtl/calc_iter_unit.sv
// calc_iter_unit: iterative multiply / divide datapath, one step per cycle.
// Multiply is LSB-first shift-add; divide is MSB-first restoring division.
// The divider path exists only when CALC_ALU_DIV_EN is defined.
// value_o is the value the accumulator takes on the current step, so the
// caller can register it on the same edge that last_o is high.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic           clk_sw,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           mode_i,   // 1 = divide, 0 = multiply
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           last_o,
  output logic [2*W-1:0] value_o
);

  localparam int CW = $clog2(W + 1);

  // acc_q = {hi, lo}: mul keeps partial product in hi and the remaining
  // multiplier bits in lo; div keeps remainder in hi and the dividend
  // shifting out of / quotient shifting into lo.
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [W-1:0]   opnd_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     mul_sum;
`ifdef CALC_ALU_DIV_EN
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_rem;
`endif

  // Next accumulator value for one mul or div step.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
`ifdef CALC_ALU_DIV_EN
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_ge ? W'(div_shift - {1'b0, opnd_q}) : div_shift[W-1:0];
    if (mode_i) begin
      acc_d = {div_rem, acc_q[W-2:0], div_ge};
    end else begin
      acc_d = {mul_sum, acc_q[W-1:1]};
    end
`else
    acc_d = mode_i ? '0 : {mul_sum, acc_q[W-1:1]};
`endif
  end

  assign value_o = acc_d;
  assign last_o  = step_i && (cnt_q == CW'(W - 1));

  // Operand load on accept, then one step per enabled cycle.
  always_ff @(posedge clk_sw) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      acc_q  <= {{W{1'b0}}, (mode_i ? a_i : b_i)};
      opnd_q <= mode_i ? b_i : a_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q  <= acc_d;
      cnt_q  <= last_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/calc_alu.sv
// calc_alu: calculator arithmetic stage. Snapshots operands and op on an
// accepted start, computes add/sub in one cycle and mul/div over W steps,
// and presents a registered result with a one-cycle done pulse.
// Optional feature macro: CALC_ALU_DIV_EN (enables the restoring divider;
// without it op 3 reports err with result 0).
module calc_alu
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic     clk_sw,
  input  logic     rst_n,
  calc_alu_if.slave bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CALC = ST_CALC;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]     state_q;
  op_e            op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] result_q;
  logic           neg_q;
  logic           err_q;
  logic           done_q;

  logic           accept;
  logic [W:0]     add_sum;
  logic           sub_ge;
  logic [W-1:0]   sub_mag;
  logic           iter_mode;
  logic           iter_step;
  logic           iter_last;
  logic [2*W-1:0] iter_value;

  // Accept decode, single-cycle arithmetic and iterative-unit controls.
  always_comb begin
    accept    = (state_q == S_IDLE) && bus.start;
    add_sum   = {1'b0, a_q} + {1'b0, b_q};
    sub_ge    = (a_q >= b_q);
    sub_mag   = sub_ge ? (a_q - b_q) : (b_q - a_q);
    // At accept the mode must come from the live op, afterwards from the snapshot.
    iter_mode = accept ? (op_e'(bus.op) == OP_DIV) : (op_q == OP_DIV);
`ifdef CALC_ALU_DIV_EN
    iter_step = (state_q == S_CALC) &&
                ((op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0)));
`else
    iter_step = (state_q == S_CALC) && (op_q == OP_MUL);
`endif
  end

  calc_iter_unit #(.W(W)) u_iter (
    .clk_sw  (clk_sw),
    .rst_n   (rst_n),
    .load_i  (accept),
    .step_i  (iter_step),
    .mode_i  (iter_mode),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .last_o  (iter_last),
    .value_o (iter_value)
  );

  // FSM, operand snapshot and output registers; results hold until the next done.
  always_ff @(posedge clk_sw) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= op_e'(bus.op);
            a_q     <= bus.a;
            b_q     <= bus.b;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          case (op_q)
            OP_ADD: begin
              result_q <= {{(W-1){1'b0}}, add_sum};
              neg_q    <= 1'b0;
              err_q    <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
            OP_SUB: begin
              result_q <= {{W{1'b0}}, sub_mag};
              neg_q    <= ~sub_ge;
              err_q    <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
            OP_MUL: begin
              if (iter_last) begin
                result_q <= iter_value;
                neg_q    <= 1'b0;
                err_q    <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end
            end
            default: begin
`ifdef CALC_ALU_DIV_EN
              if (b_q == '0) begin
                result_q <= '1;
                neg_q    <= 1'b0;
                err_q    <= 1'b1;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end else if (iter_last) begin
                result_q <= iter_value;
                neg_q    <= 1'b0;
                err_q    <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end
`else
              result_q <= '0;
              neg_q    <= 1'b0;
              err_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
`endif
            end
          endcase
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_calc_alu.sv
// tb_calc_alu: directed-vector bench for calc_alu with hand-computed results.
// Divide expectations follow CALC_ALU_DIV_EN as the design does.
module tb_calc_alu;

  localparam int W = 4;

  logic clk_sw = 1'b0;
  logic rst_n  = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] prev_res = 8'h00;

  calc_alu_if #(.W(W)) bus ();

  calc_alu #(.W(W)) dut (
    .clk_sw (clk_sw),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk_sw = ~clk_sw;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One transaction: start at edge 0, scramble inputs, wait for done, check.
  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                        input logic [1:0] top, input int exp_lat,
                        input logic [7:0] exp_res, input logic exp_neg, input logic exp_err);
    int lat;
    logic seen;
    bus.a = ta; bus.b = tb; bus.op = top; bus.start = 1'b1;
    @(posedge clk_sw); #1;
    bus.start = 1'b0;
    bus.a = ~ta; bus.b = ~tb; bus.op = top ^ 2'd1;
    chk({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    chk({tag, "_hold_prev"}, 32'(bus.result), 32'(prev_res));
    lat = 0; seen = 1'b0;
    while (!seen && lat < 16) begin
      @(posedge clk_sw); #1;
      lat++;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    chk({tag, "_neg"}, 32'(bus.neg), 32'(exp_neg));
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    @(posedge clk_sw); #1;
    chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_result_held"}, 32'(bus.result), 32'(exp_res));
    prev_res = exp_res;
    $display("txn %s a=%0d b=%0d op=%0d lat=%0d result=0x%02h neg=%0b err=%0b",
             tag, ta, tb, top, lat, bus.result, bus.neg, bus.err);
  endtask

  initial begin
    int n_done;
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_sw);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_neg", 32'(bus.neg), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    $display("txn reset busy=%0b done=%0b result=0x%02h", bus.busy, bus.done, bus.result);
    rst_n = 1'b1;
    @(posedge clk_sw); #1;

    // add 7+5 with start held high through DONE: exactly one done pulse
    bus.a = 4'd7; bus.b = 4'd5; bus.op = 2'd0; bus.start = 1'b1;
    @(posedge clk_sw); #1;
    n_done = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_sw); #1;
      if (bus.done) n_done++;
      if (k == 1) begin
        chk("add_hold_done_e1", 32'(bus.done), 32'd1);
        chk("add_hold_result", 32'(bus.result), 32'h0C);
        chk("add_hold_neg", 32'(bus.neg), 32'd0);
        chk("add_hold_err", 32'(bus.err), 32'd0);
      end
      if (k == 2) bus.start = 1'b0;
    end
    chk("add_hold_one_pulse", 32'(n_done), 32'd1);
    prev_res = 8'h0C;
    $display("txn add_hold a=7 b=5 dones=%0d result=0x%02h", n_done, bus.result);

    run_op("sub_neg", 4'd3, 4'd9, 2'd1, 1, 8'd6, 1'b1, 1'b0);
    run_op("sub_pos", 4'd9, 4'd3, 2'd1, 1, 8'd6, 1'b0, 1'b0);
    run_op("sub_eq", 4'd5, 4'd5, 2'd1, 1, 8'd0, 1'b0, 1'b0);
    run_op("add_max", 4'd15, 4'd15, 2'd0, 1, 8'd30, 1'b0, 1'b0);
    run_op("mul_max", 4'd15, 4'd15, 2'd2, 4, 8'hE1, 1'b0, 1'b0);
    run_op("mul_6x7", 4'd6, 4'd7, 2'd2, 4, 8'd42, 1'b0, 1'b0);
    run_op("mul_zero", 4'd0, 4'd9, 2'd2, 4, 8'd0, 1'b0, 1'b0);
`ifdef CALC_ALU_DIV_EN
    run_op("div_13_4", 4'd13, 4'd4, 2'd3, 4, 8'h13, 1'b0, 1'b0);
    run_op("div_15_1", 4'd15, 4'd1, 2'd3, 4, 8'h0F, 1'b0, 1'b0);
    run_op("div_7_9", 4'd7, 4'd9, 2'd3, 4, 8'h70, 1'b0, 1'b0);
    run_op("div_by0", 4'd9, 4'd0, 2'd3, 1, 8'hFF, 1'b0, 1'b1);
    run_op("add_errclr", 4'd1, 4'd2, 2'd0, 1, 8'd3, 1'b0, 1'b0);
    run_op("div_by0_b", 4'd4, 4'd0, 2'd3, 1, 8'hFF, 1'b0, 1'b1);
`else
    run_op("div_off", 4'd13, 4'd4, 2'd3, 1, 8'h00, 1'b0, 1'b1);
    run_op("add_errclr", 4'd1, 4'd2, 2'd0, 1, 8'd3, 1'b0, 1'b0);
    run_op("div_off_b", 4'd9, 4'd0, 2'd3, 1, 8'h00, 1'b0, 1'b1);
`endif
    run_op("mul_pre_rst", 4'd3, 4'd5, 2'd2, 4, 8'd15, 1'b0, 1'b0);
    run_op("sub_pre_rst", 4'd2, 4'd7, 2'd1, 1, 8'd5, 1'b1, 1'b0);

    // mul 15*15 aborted by reset sampled at edge 2
    bus.a = 4'd15; bus.b = 4'd15; bus.op = 2'd2; bus.start = 1'b1;
    @(posedge clk_sw); #1;
    bus.start = 1'b0;
    @(posedge clk_sw); #1;
    rst_n = 1'b0;
    @(posedge clk_sw); #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_neg", 32'(bus.neg), 32'd0);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_sw); #1;
      if (bus.done) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_idle_result", 32'(bus.result), 32'd0);
    $display("txn abort mul dones=%0d busy=%0b result=0x%02h", n_done, bus.busy, bus.result);
    prev_res = 8'h00;
    run_op("add_after_rst", 4'd7, 4'd5, 2'd0, 1, 8'h0C, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_alu.md
# calc_alu

Arithmetic stage of the calculator, directly downstream of the switch-capture stage that latches the two 4-bit operands. On a start pulse it snapshots both operands and an operation code, then computes add, subtract, multiply or divide. Add/subtract take one cycle; multiply/divide take W iterations of a shift-add or restoring-divide loop. It presents a registered 2W-bit result with a one-cycle done pulse for the display stage.

## Interface
Parameters:
- W, default 4, operand width in bits; result is 2W bits.

Ports:
- clk_sw  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk_sw.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  operation: 0 add, 1 sub, 2 mul, 3 div.
- a  in  W  first operand (the stage-1 operand register), unsigned.
- b  in  W  second operand, unsigned.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse; result, neg and err valid from this cycle on.
- result  out  2W  registered result.
- neg  out  1  sub result negative; result holds the magnitude.
- err  out  1  divide by zero, or division compiled out.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE to CALC on start=1.
  - CALC to DONE when the operation completes.
  - DONE to IDLE unconditionally.
- On accept, a, b and op are captured into internal registers. Later input changes have no effect on the operation in flight.
- start is ignored in CALC and DONE; there is no queueing.
- add: result = zero-extended a+b (max 2^(W+1)-2), neg=0.
- sub: if a>=b, result = a-b and neg=0; otherwise result = b-a and neg=1.
- mul: unsigned shift-add over W iterations, one multiplier bit per cycle, LSB first. result = a*b.
- div: restoring division over W iterations, MSB first. result[2W-1:W] = remainder, result[W-1:0] = quotient.
- div with b=0: no iteration. err=1, result = all ones, with add/sub latency.
- result, neg and err are held from done until the next accepted start. At that start they keep their previous values until the new done.
- err is cleared on every successful completion.
- Reset values: state IDLE, busy=0, done=0, result=0, neg=0, err=0, iteration counter 0.
- Reset mid-operation aborts immediately. No done is issued, and outputs take their reset values.

## Timing
- Call the clock edge that samples start=1 edge 0.
- add, sub, div-by-zero: result registered at edge 1; done=1 during the cycle after edge 1.
- mul, div: one iteration per edge, edges 1..W. Result registered at edge W; done=1 during the cycle after edge W (W=4 means 4 edges).
- busy=1 from edge 0 until edge N+1, where N is the operation latency. The next start is accepted no earlier than edge N+1, which allows back-to-back operations.
- done is high for exactly one cycle per accepted start.

## Configuration
- CALC_ALU_DIV_EN defined: op 3 performs the restoring divide described above.
- CALC_ALU_DIV_EN undefined: the divider datapath is removed. op 3 completes with add/sub latency, err=1, result=0, neg=0.

## Structure
- Package calc_pkg holds:
  - the op enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV),
  - the FSM state enum,
  - CALC_W = 4 as the default operand width.
- Sub-module calc_iter_unit: the iterative mul/div datapath with its own iteration counter. Inputs are load, mode and operands; outputs are a last-iteration flag and the 2W-bit value. The top level holds the FSM, add/sub logic and output registers.

## Test plan
- Reset, then a=7, b=5, op=add, start -> done after edge 1, result=12 (0x0C), neg=0, err=0. Hold start high through DONE -> exactly one done pulse.
- a=3, b=9, op=sub -> result=6, neg=1, done after edge 1. Then a=9, b=3, op=sub -> result=6, neg=0.
- a=15, b=15, op=mul -> busy for edges 0..4, done after edge 4, result=225 (0xE1). Changing a/b during CALC does not change the result.
- a=13, b=4, op=div -> done after edge 4, result=0x13 (remainder 1, quotient 3). Then a=9, b=0, op=div -> done after edge 1, err=1, result=0xFF.
- Start mul 15*15, assert rst_n=0 at edge 2 -> no done; busy, result, neg and err are 0 after that edge. A new add start is accepted normally afterwards.
- Build without CALC_ALU_DIV_EN: a=13, b=4, op=div -> done after edge 1, err=1, result=0.
